// File: rtl/debug_dump_pkg.sv
// Shared types and constants for the debug register dump transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debug_dump_pkg;

   // Dump sequencer states
   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      LATCH,
      SEND,
      DONE
   } state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int SEL_W          = 5;
   localparam int SETTLE_W       = 4;
   localparam int BCNT_W         = 2;

endpackage

// File: rtl/word_byte_serializer.sv
// Loads one 32-bit word and emits it as four bytes, MSB first, on a valid/ready stream.
// Latency: first byte valid the cycle after load_i; one byte per cycle while tx_ready_i is high.
// Backpressure: holds tx_valid_o/tx_data_o stable until tx_ready_i; tx_valid_o never depends on tx_ready_i.
module word_byte_serializer
   import debug_dump_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        load_i,
   input  logic [31:0] word_i,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   output logic        last_o
);

   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

   logic [31:0]       word_q, word_d;
   logic [BCNT_W-1:0] cnt_q, cnt_d;
   logic              vld_q, vld_d;
   logic              fire;

   assign fire       = vld_q & tx_ready_i;
   assign tx_data_o  = word_q[31:24];
   assign tx_valid_o = vld_q;
   assign last_o     = fire && (cnt_q == LAST_BYTE);

   // Next-state: load a fresh word, or shift out one byte per accepted handshake
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      if (load_i) begin
         word_d = word_i;
         cnt_d  = '0;
         vld_d  = 1'b1;
      end else if (fire) begin
         word_d = {word_q[23:0], 8'h00};
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q == LAST_BYTE) begin
            vld_d = 1'b0;
         end
      end
   end

   // Shift register, byte count and valid flag
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         word_q <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: rtl/debug_reg_dump_tx.sv
// Walks debug indices 0..NUM_REGS-1, latches each Debug_out word and streams it MSB-first as bytes; DUMP_PC_EN prepends the PC word.
// Latency: (SETTLE_CYCLES+5) cycles per register with tx_ready high; done at (SETTLE_CYCLES+5)*NUM_REGS+1 (+4 with DUMP_PC_EN).
// Backpressure: tx_ready low stalls only the SEND state; no byte is lost or duplicated.
module debug_reg_dump_tx
   import debug_dump_pkg::*;
#(
   parameter int NUM_REGS      = 32,   // 1..32
   parameter int SETTLE_CYCLES = 1     // 1..15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] Debug_out,
   input  logic [31:0] PC,
   output logic [4:0]  Debug_source_select,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [SEL_W-1:0]    LAST_SEL   = SEL_W'(NUM_REGS - 1);
   localparam logic [SETTLE_W-1:0] LAST_SETTL = SETTLE_W'(SETTLE_CYCLES - 1);

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pc_word_q, pc_word_d;   // word in flight is the PC, not a register
   logic                load;
   logic [31:0]         word_src;
   logic                ser_last;

`ifndef DUMP_PC_EN
   logic unused_pc;
   assign unused_pc = ^PC;
`endif

   assign Debug_source_select = sel_q;
   assign busy                = busy_q;
   assign done                = done_q;

   // Sequencer next-state: select, settle, latch, send, advance index
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      settle_d  = settle_q;
      pc_word_d = pc_word_q;
      load      = 1'b0;
      word_src  = Debug_out;
      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d    = '0;
               settle_d = '0;
`ifdef DUMP_PC_EN
               load      = 1'b1;
               word_src  = PC;
               pc_word_d = 1'b1;
               state_d   = SEND;
`else
               state_d   = SELECT;
`endif
            end
         end
         SELECT: begin
            if (settle_q == LAST_SETTL) begin
               state_d = LATCH;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         LATCH: begin
            load    = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (ser_last) begin
               settle_d = '0;
               if (pc_word_q) begin
                  // PC word finished; register walk starts at index 0
                  pc_word_d = 1'b0;
                  state_d   = SELECT;
               end else if (sel_q == LAST_SEL) begin
                  state_d = DONE;
               end else begin
                  sel_d   = sel_q + 1'b1;
                  state_d = SELECT;
               end
            end
         end
         DONE: begin
            sel_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == SELECT) || (state_d == LATCH) || (state_d == SEND);
      done_d = (state_d == DONE);
   end

   // Sequencer state, index, settle counter and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         settle_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pc_word_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         settle_q  <= settle_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pc_word_q <= pc_word_d;
      end
   end

   word_byte_serializer u_ser (
      .clk_i      (clk),
      .reset_i    (reset),
      .load_i     (load),
      .word_i     (word_src),
      .tx_data_o  (tx_data),
      .tx_valid_o (tx_valid),
      .tx_ready_i (tx_ready),
      .last_o     (ser_last)
   );

endmodule

// File: doc/debug_reg_dump_tx.md
Name: debug_reg_dump_tx

Overview:
- Host side of the processor's debug port: drives `Debug_source_select` and reads back `Debug_out`.
- On a `start` pulse it walks register indices 0..NUM_REGS-1 and latches each 32-bit value.
- Each value is sent as four bytes, MSB first, over a valid/ready byte stream that feeds the board UART transmitter.
- Sits beside the single-cycle processor top in the FPGA wrapper, so the register file can be dumped without halting the clock.

Parameters:
- NUM_REGS, 32, number of debug indices dumped (legal range 1..32).
- SETTLE_CYCLES, 1, cycles `Debug_source_select` is held before `Debug_out` is sampled (legal range 1..15).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; ignored while busy.
- Debug_out  input  32  debug read data from the processor.
- PC  input  32  processor program counter; used only with the optional feature.
- Debug_source_select  output  5  debug index currently selected.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  `tx_data` is valid.
- tx_ready  input  1  sink accepts the byte when `tx_valid && tx_ready`.
- busy  output  1  high from the cycle after `start` is accepted until DONE.
- done  output  1  one-cycle pulse at the end of a dump.

Behaviour:
- Reset values: state=IDLE, `Debug_source_select`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0, byte count=0, word register=0.
- States:
  - IDLE: when `start`=1, go to SELECT with sel=0 and clear the settle counter.
  - SELECT: hold sel for SETTLE_CYCLES cycles, then go to LATCH.
  - LATCH: capture `Debug_out` into the word register, go to SEND.
  - SEND: `tx_valid`=1 and `tx_data`=word[31:24]. On each handshake, shift the word left by 8 and increment the byte count. After the 4th handshake:
    - if sel==NUM_REGS-1, go to DONE;
    - otherwise sel+1 and go to SELECT.
  - DONE: `done`=1 for one cycle, `busy` drops, go to IDLE.
- Handshake rules:
  - Once `tx_valid` is asserted, it and `tx_data` stay stable until `tx_ready`.
  - `tx_valid` never depends combinationally on `tx_ready`.
- `Debug_out` may change freely during SEND; only the value captured in LATCH is sent.
- Latency with `tx_ready` held high: (SETTLE_CYCLES+5) cycles per register. `done` asserts (SETTLE_CYCLES+5)*NUM_REGS+1 cycles after the `start` edge; that is 193 with defaults.
- Back-pressure stalls only SEND; no byte is lost or duplicated.
- `start` while `busy`=1 has no effect: it is not queued and the dump is not restarted.
- `start` in the DONE cycle is ignored.
- Reset mid-dump: on the next edge all registers return to reset values; any partially sent word is abandoned.
- `Debug_source_select` is a 5-bit counter with no wrap past NUM_REGS-1; it returns to 0 in DONE.

Optional Feature:
- Macro: DUMP_PC_EN.
- When defined:
  - in the `start` cycle, `PC` is latched into the word register and the FSM goes directly to SEND;
  - the PC bytes are sent first, then the register walk proceeds unchanged;
  - total bytes = 4*(NUM_REGS+1) and `done` latency increases by 4 cycles with `tx_ready` high.
- When undefined: the `PC` port exists but is unused; total bytes = 4*NUM_REGS.

Decomposition:
- Package debug_dump_pkg holds:
  - state encoding: IDLE, SELECT, LATCH, SEND, DONE;
  - BYTES_PER_WORD=4;
  - SEL_W=5;
  - SETTLE_W=4.
- One sub-module, word_byte_serializer:
  - loads a 32-bit word and emits 4 bytes MSB-first on valid/ready;
  - reports last-byte accepted;
  - owns the shift register and byte count.
- The top-level FSM owns sel, the settle counter, `busy` and `done`.

Test Plan:
- Dump with defaults and `tx_ready`=1. Model `Debug_out`=sel*0x01010101, so x1=0x01010101 and x31=0x1F1F1F1F. Expect 128 bytes; bytes 4-7 = 01 01 01 01; `done` at cycle 193.
- Back-pressure: `tx_ready` random 30% duty with x5=0xDEADBEEF. Expect bytes DE AD BE EF in order, `tx_data` stable while stalled, byte count exactly 128.
- `start` re-pulsed at cycles 10 and 100 of a dump. Expect a single `done` and still 128 bytes.
- Reset asserted at cycle 50. Expect `tx_valid`=0, `busy`=0 and `Debug_source_select`=0 next cycle. A new `start` produces a full, correct dump.
- NUM_REGS=1, SETTLE_CYCLES=3. Expect exactly 4 bytes of x0 (00 00 00 00); `done` at cycle 9.
- With DUMP_PC_EN and `PC`=0x00000040 at start: first bytes are 00 00 00 40, then 128 register bytes; `done` at cycle 197.
